// File: rtl/decoder_pkg.sv
// Shared constants and decode helper for the streaming one-hot decoders.
// Widths are kept here so a wider variant can reuse the same helper.
package decoder_pkg;

    localparam int CODE_W   = 2;
    localparam int ONEHOT_W = 1 << CODE_W;

    // A disabled code still yields an entry (all zeros) so it keeps its FIFO slot.
    function automatic logic [ONEHOT_W-1:0] onehot_decode(
        input logic [CODE_W-1:0] code,
        input logic              en
    );
        logic [ONEHOT_W-1:0] word;
        word = '0;
        if (en) begin
            word[code] = 1'b1;
        end
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO with a registered occupancy count.
// full/empty come only from the count, so there is no combinational bypass.
module sync_fifo2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/decoder_2to4_stream.sv
// Streaming 2-to-4 decoder: decodes accepted codes into a 2-entry output FIFO
// and keeps saturating per-code hit counters for debug readback.
module decoder_2to4_stream
    import decoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CODE_W-1:0]   in_code,
    input  logic                in_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ONEHOT_W-1:0] out_d,
    input  logic [1:0]          cnt_sel,
    output logic [CNT_W-1:0]    cnt_val,
    input  logic                cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                fifo_full;
    logic                fifo_empty;
    logic                accept;
    logic [ONEHOT_W-1:0] entry;
    logic [CNT_W-1:0]    cnt [ONEHOT_W];

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign accept    = in_valid && in_ready;
    assign entry     = onehot_decode(in_code, in_en);

    sync_fifo2 #(
        .W (ONEHOT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (out_ready),
        .din   (entry),
        .dout  (out_d),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Clear wins over a same-cycle hit; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            for (int i = 0; i < ONEHOT_W; i++) begin
                cnt[i] <= '0;
            end
        end else if (accept && in_en && (cnt[in_code] != CNT_MAX)) begin
            cnt[in_code] <= cnt[in_code] + 1'b1;
        end
    end

    assign cnt_val = cnt[cnt_sel];

endmodule

// File: tb/tb_decoder_2to4_stream.sv
// Directed bench for decoder_2to4_stream, built with 2-bit counters so
// saturation is reachable in a few accepts.
module tb_decoder_2to4_stream;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_code;
    logic             in_en;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_d;
    logic [1:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_clr;

    int checks   = 0;
    int failures = 0;
    int exp_cnt [4];

    typedef struct {
        logic [1:0] code;
        logic       en;
        logic [3:0] exp_d;
    } vec_t;

    vec_t vecs [7];

    decoder_2to4_stream #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_en     (in_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .cnt_sel   (cnt_sel),
        .cnt_val   (cnt_val),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        for (int s = 0; s < 4; s++) begin
            cnt_sel = s[1:0];
            #1;
            check($sformatf("%s cnt[%0d]", tag, s), 8'(cnt_val), 8'(exp_cnt[s]));
        end
    endtask

    initial begin
        vecs[0] = '{2'b00, 1'b1, 4'b0001};
        vecs[1] = '{2'b01, 1'b1, 4'b0010};
        vecs[2] = '{2'b10, 1'b1, 4'b0100};
        vecs[3] = '{2'b11, 1'b1, 4'b1000};
        vecs[4] = '{2'b11, 1'b0, 4'b0000};
        vecs[5] = '{2'b01, 1'b0, 4'b0000};
        vecs[6] = '{2'b10, 1'b1, 4'b0100};
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

        // Reset with a handshake pending: nothing may be accepted or counted.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'b11;
        in_en     = 1'b1;
        out_ready = 1'b1;
        cnt_sel   = 2'd0;
        cnt_clr   = 1'b0;
        step();
        step();
        check("reset out_valid", 8'(out_valid), 8'd0);
        check("reset out_d", 8'(out_d), 8'd0);
        check("reset in_ready", 8'(in_ready), 8'd1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        check("post-reset out_valid", 8'(out_valid), 8'd0);
        check_counters("reset");

        // Streaming decode with out_ready held high: one-cycle latency each.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_code  = vecs[i].code;
            in_en    = vecs[i].en;
            check($sformatf("vec%0d in_ready", i), 8'(in_ready), 8'd1);
            step();
            check($sformatf("vec%0d out_valid", i), 8'(out_valid), 8'd1);
            check($sformatf("vec%0d out_d", i), 8'(out_d), 8'(vecs[i].exp_d));
            if (vecs[i].en && exp_cnt[vecs[i].code] < 3) exp_cnt[vecs[i].code]++;
        end
        in_valid = 1'b0;
        step();
        check("drain out_valid", 8'(out_valid), 8'd0);
        check("drain out_d", 8'(out_d), 8'd0);
        check_counters("stream");

        // Backpressure: two accepts fill the FIFO, third is held off.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_en     = 1'b1;
        in_code   = 2'b01;
        step();
        check("bp1 in_ready", 8'(in_ready), 8'd1);
        check("bp1 out_d", 8'(out_d), 8'b0010);
        in_code = 2'b10;
        step();
        check("bp2 in_ready", 8'(in_ready), 8'd0);
        check("bp2 out_d", 8'(out_d), 8'b0010);
        in_code = 2'b11;
        step();
        check("bp3 in_ready", 8'(in_ready), 8'd0);
        check("bp3 out_d", 8'(out_d), 8'b0010);
        out_ready = 1'b1;
        step();
        check("bp pop1 out_d", 8'(out_d), 8'b0100);
        check("bp pop1 in_ready", 8'(in_ready), 8'd1);
        step();
        check("bp pop2 out_d", 8'(out_d), 8'b1000);
        check("bp pop2 out_valid", 8'(out_valid), 8'd1);
        in_valid = 1'b0;
        step();
        check("bp empty out_valid", 8'(out_valid), 8'd0);
        for (int c = 1; c < 4; c++) if (exp_cnt[c] < 3) exp_cnt[c]++;
        check_counters("bp");

        // Clear, then saturate counter 2 and clear on top of a hit.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        check_counters("clr");
        cnt_sel  = 2'd2;
        in_valid = 1'b1;
        in_code  = 2'b10;
        in_en    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("sat%0d cnt2", k), 8'(cnt_val), 8'((k < 3) ? k + 1 : 3));
        end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr+hit cnt2", 8'(cnt_val), 8'd0);
        step();
        check("after clr cnt2", 8'(cnt_val), 8'd1);
        in_valid = 1'b0;
        cnt_sel  = 2'd3;
        #1;
        check("sel mux cnt3", 8'(cnt_val), 8'd0);
        step();

        // Reset mid-stream discards both buffered entries.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'b00;
        step();
        in_code = 2'b11;
        step();
        check("mid full in_ready", 8'(in_ready), 8'd0);
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        check("mid rst out_valid", 8'(out_valid), 8'd0);
        check("mid rst in_ready", 8'(in_ready), 8'd1);
        check("mid rst out_d", 8'(out_d), 8'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("mid stale%0d out_valid", k), 8'(out_valid), 8'd0);
        end
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        check_counters("mid rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
